// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the memory request/grant/response
// handshake, presents one instruction to IF/ID and arbitrates ID/EX branch redirects.
module if_fetch_ctrl #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_i,
  input  logic              id_b_flag_i,
  input  logic [ADDR_W-1:0] id_b_target_i,
  input  logic              ex_b_flag_i,
  input  logic [ADDR_W-1:0] ex_b_target_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              stall_req_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DROP  = 3'd4;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              inst_valid_reg, inst_valid_next;
  logic [INST_W-1:0] inst_reg, inst_next;
  logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
  logic              mem_req_reg;
  logic              flush_if_id_reg, flush_id_ex_reg;
  logic              stall_req_reg;

  logic              redirect;
  logic              ex_redirect;
  logic [ADDR_W-1:0] redirect_target;

  // EX is the older instruction, so its redirect wins over ID's.
  assign redirect        = (state_reg != IDLE) && (ex_b_flag_i || id_b_flag_i);
  assign ex_redirect     = (state_reg != IDLE) && ex_b_flag_i;
  assign redirect_target = ex_b_flag_i ? ex_b_target_i : id_b_target_i;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    inst_valid_next = inst_valid_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_next    = redirect_target;
          // A grant in the redirect cycle leaves a stale response still owed.
          state_next = mem_gnt_i ? DROP : FETCH;
        end else if (mem_gnt_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = mem_rvalid_i ? FETCH : DROP;
        end else if (mem_rvalid_i) begin
          inst_next       = mem_rdata_i;
          inst_pc_next    = pc_reg;
          inst_valid_next = 1'b1;
          state_next      = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next         = redirect_target;
          inst_valid_next = 1'b0;
          state_next      = FETCH;
        end else if (!if_stall_i) begin
          pc_next         = pc_reg + ADDR_W'(4);
          inst_valid_next = 1'b0;
          state_next      = FETCH;
        end
      end
      DROP: begin
        if (redirect) pc_next = redirect_target;
        if (mem_rvalid_i) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      inst_valid_reg  <= 1'b0;
      inst_reg        <= '0;
      inst_pc_reg     <= '0;
      mem_req_reg     <= 1'b0;
      flush_if_id_reg <= 1'b0;
      flush_id_ex_reg <= 1'b0;
      stall_req_reg   <= 1'b1;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      inst_valid_reg  <= inst_valid_next;
      inst_reg        <= inst_next;
      inst_pc_reg     <= inst_pc_next;
      mem_req_reg     <= (state_next == FETCH);
      flush_if_id_reg <= redirect;
      flush_id_ex_reg <= ex_redirect;
      stall_req_reg   <= ~inst_valid_next;
    end
  end

  assign mem_req_o     = mem_req_reg;
  assign mem_addr_o    = pc_reg;
  assign inst_valid_o  = inst_valid_reg;
  assign inst_o        = inst_reg;
  assign inst_pc_o     = inst_pc_reg;
  assign flush_if_id_o = flush_if_id_reg;
  assign flush_id_ex_o = flush_id_ex_reg;
  assign stall_req_o   = stall_req_reg;

endmodule
